cpu_datapath: RTL and testbench

Register-transfer datapath driven by the microprogrammed control unit's 32-bit control word. Holds PC, MAR, MBR, IR, BR and ACC, executes ALU operations including a multi-cycle unsigned divider, drives the single-port instruction/data memory, and returns IR and ALU flags to the control unit. The block sits between the control unit and the memory in the CPU top level.

---
 rtl/cpu_datapath.sv | 241 ++++++++++++++++++++++++
 tb/tb_cpu_datapath.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_datapath.sv
// Register-transfer datapath for the microprogrammed CPU: PC/MAR/MBR/IR/BR/ACC,
// flag-producing ALU and a multi-cycle unsigned restoring divider.
module cpu_datapath #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] ir_out,
    output logic [3:0]        alu_flags,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out,
    output logic              div_busy
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    logic [ADDR_W-1:0] pc_r, mar_r, ir_r;
    logic [DATA_W-1:0] mbr_r, br_r, acc_r;
    logic              zf_r, cf_r, of_r, sf_r;
    div_state_t        div_state_r;
    logic              div_busy_r;
    logic [CNT_W-1:0]  div_cnt_r;
    logic [DATA_W-1:0] div_quot_r, div_rem_r, div_dvsr_r;

    logic [DATA_W:0]     sum_s, diff_s, shl_s, shr_s;
    logic [2*DATA_W-1:0] prod_s, div_next_s;
    logic [DATA_W-1:0]   acc_res_s;
    logic                acc_we_s, cf_res_s, of_res_s, div_start_s;
    logic                ctrl_unused_s;

    // Logical shift by up to 31 places; returns {last bit shifted out, result}.
    function automatic logic [DATA_W:0] shift_op(input logic [DATA_W-1:0] val,
                                                 input logic [4:0] amt,
                                                 input logic left);
        logic [DATA_W-1:0] res;
        logic              cf;
        res = val;
        cf  = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (5'(i) < amt) begin
                if (left) begin
                    cf  = res[DATA_W-1];
                    res = {res[DATA_W-2:0], 1'b0};
                end else begin
                    cf  = res[0];
                    res = {1'b0, res[DATA_W-1:1]};
                end
            end
        end
        return {cf, res};
    endfunction

    // One restoring-division iteration; returns {next remainder, next quotient}.
    function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem,
                                                     input logic [DATA_W-1:0] quot,
                                                     input logic [DATA_W-1:0] dvsr);
        logic [DATA_W:0] trial;
        trial = {rem, quot[DATA_W-1]};
        if (trial >= {1'b0, dvsr}) begin
            return {DATA_W'(trial - {1'b0, dvsr}), quot[DATA_W-2:0], 1'b1};
        end else begin
            return {trial[DATA_W-1:0], quot[DATA_W-2:0], 1'b0};
        end
    endfunction

    assign sum_s      = {1'b0, acc_r} + {1'b0, br_r};
    assign diff_s     = {1'b0, acc_r} - {1'b0, br_r};
    assign prod_s     = acc_r * br_r;
    assign shl_s      = shift_op(acc_r, br_r[4:0], 1'b1);
    assign shr_s      = shift_op(acc_r, br_r[4:0], 1'b0);
    assign div_next_s = div_step(div_rem_r, div_quot_r, div_dvsr_r);
    assign ctrl_unused_s = ^{ctrl[31:22], ctrl[2:0]};

    // ACC operation select: NOT first, then the lowest-numbered op bit; frozen while dividing.
    always_comb begin
        acc_we_s    = 1'b0;
        acc_res_s   = acc_r;
        cf_res_s    = 1'b0;
        of_res_s    = 1'b0;
        div_start_s = 1'b0;
        if (div_busy_r) begin
            acc_we_s = 1'b0;
        end else if (ctrl[21]) begin
            acc_we_s  = 1'b1;
            acc_res_s = ~br_r;
        end else if (ctrl[8]) begin
            acc_we_s  = 1'b1;
            acc_res_s = {DATA_W{1'b0}};
        end else if (ctrl[9]) begin
            acc_we_s  = 1'b1;
            acc_res_s = sum_s[DATA_W-1:0];
            cf_res_s  = sum_s[DATA_W];
            of_res_s  = (acc_r[DATA_W-1] == br_r[DATA_W-1]) &&
                        (sum_s[DATA_W-1] != acc_r[DATA_W-1]);
        end else if (ctrl[13]) begin
            acc_we_s  = 1'b1;
            acc_res_s = diff_s[DATA_W-1:0];
            cf_res_s  = diff_s[DATA_W];
            of_res_s  = (acc_r[DATA_W-1] != br_r[DATA_W-1]) &&
                        (diff_s[DATA_W-1] != acc_r[DATA_W-1]);
        end else if (ctrl[15]) begin
            acc_we_s  = 1'b1;
            acc_res_s = prod_s[DATA_W-1:0];
            cf_res_s  = |prod_s[2*DATA_W-1:DATA_W];
            of_res_s  = |prod_s[2*DATA_W-1:DATA_W];
        end else if (ctrl[16]) begin
            if (br_r == {DATA_W{1'b0}}) begin
                acc_we_s  = 1'b1;
                acc_res_s = {DATA_W{1'b1}};
                cf_res_s  = 1'b1;
            end else begin
                div_start_s = 1'b1;
            end
        end else if (ctrl[17]) begin
            acc_we_s  = 1'b1;
            acc_res_s = shl_s[DATA_W-1:0];
            cf_res_s  = shl_s[DATA_W];
        end else if (ctrl[18]) begin
            acc_we_s  = 1'b1;
            acc_res_s = shr_s[DATA_W-1:0];
            cf_res_s  = shr_s[DATA_W];
        end else if (ctrl[19]) begin
            acc_we_s  = 1'b1;
            acc_res_s = acc_r & br_r;
        end else if (ctrl[20]) begin
            acc_we_s  = 1'b1;
            acc_res_s = acc_r | br_r;
        end else begin
            acc_we_s = 1'b0;
        end
    end

    // Register transfers outside the ACC path.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r  <= {ADDR_W{1'b0}};
            mar_r <= {ADDR_W{1'b0}};
            mbr_r <= {DATA_W{1'b0}};
            ir_r  <= {ADDR_W{1'b0}};
            br_r  <= {DATA_W{1'b0}};
        end else begin
            if (ctrl[3]) begin
                mbr_r <= mem_rdata;
            end else if (ctrl[12]) begin
                mbr_r <= acc_r;
            end
            if (ctrl[4]) begin
                ir_r <= mbr_r[DATA_W-1:ADDR_W];
            end
            if (ctrl[7]) begin
                br_r <= mbr_r;
            end
            if (ctrl[10]) begin
                mar_r <= pc_r;
            end else if (ctrl[5]) begin
                mar_r <= mbr_r[ADDR_W-1:0];
            end
            if (ctrl[14]) begin
                pc_r <= mbr_r[ADDR_W-1:0];
            end else if (ctrl[6]) begin
                pc_r <= pc_r + ADDR_W'(1);
            end
        end
    end

    // ACC, flags and divider FSM; the divider owns ACC for DATA_W cycles once started.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {DATA_W{1'b0}};
            zf_r        <= 1'b0;
            cf_r        <= 1'b0;
            of_r        <= 1'b0;
            sf_r        <= 1'b0;
            div_state_r <= DIV_IDLE;
            div_busy_r  <= 1'b0;
            div_cnt_r   <= {CNT_W{1'b0}};
            div_quot_r  <= {DATA_W{1'b0}};
            div_rem_r   <= {DATA_W{1'b0}};
            div_dvsr_r  <= {DATA_W{1'b0}};
        end else begin
            case (div_state_r)
                DIV_IDLE: begin
                    if (div_start_s) begin
                        div_state_r <= DIV_RUN;
                        div_busy_r  <= 1'b1;
                        div_cnt_r   <= {CNT_W{1'b0}};
                        div_quot_r  <= acc_r;
                        div_rem_r   <= {DATA_W{1'b0}};
                        div_dvsr_r  <= br_r;
                    end else if (acc_we_s) begin
                        acc_r <= acc_res_s;
                        zf_r  <= (acc_res_s == {DATA_W{1'b0}});
                        sf_r  <= acc_res_s[DATA_W-1];
                        cf_r  <= cf_res_s;
                        of_r  <= of_res_s;
                    end
                end
                DIV_RUN: begin
                    div_rem_r  <= div_next_s[2*DATA_W-1:DATA_W];
                    div_quot_r <= div_next_s[DATA_W-1:0];
                    if (div_cnt_r == CNT_W'(DATA_W - 1)) begin
                        div_state_r <= DIV_IDLE;
                        div_busy_r  <= 1'b0;
                        acc_r       <= div_next_s[DATA_W-1:0];
                        zf_r        <= (div_next_s[DATA_W-1:0] == {DATA_W{1'b0}});
                        sf_r        <= div_next_s[DATA_W-1];
                        cf_r        <= 1'b0;
                        of_r        <= 1'b0;
                    end else begin
                        div_cnt_r <= div_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    div_state_r <= DIV_IDLE;
                    div_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = mar_r;
    assign mem_wdata = mbr_r;
    assign mem_we    = ctrl[11];
    assign ir_out    = ir_r;
    assign alu_flags = {zf_r, cf_r, of_r, sf_r};
    assign pc_out    = pc_r;
    assign acc_out   = acc_r;
    assign div_busy  = div_busy_r;

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized self-checking bench for cpu_datapath against a cycle-level behavioural model.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl;
    logic [15:0] mem_rdata, mem_wdata, acc_out;
    logic [7:0]  mem_addr, ir_out, pc_out;
    logic        mem_we, div_busy;
    logic [3:0]  alu_flags;

    cpu_datapath #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .ir_out(ir_out), .alu_flags(alu_flags), .pc_out(pc_out),
        .acc_out(acc_out), .div_busy(div_busy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    assign mem_rdata = mem[mem_addr];

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_mem [0:255];
    logic [7:0]  m_pc, m_mar, m_ir;
    logic [15:0] m_mbr, m_br, m_acc, m_quot;
    logic [3:0]  m_flags;
    logic        m_busy;
    int          m_left;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cb(input int n);
        return 32'h1 << n;
    endfunction

    function automatic logic [3:0] flags_for(input logic [15:0] v, input logic cf, input logic of);
        return {v == 16'h0, cf, of, v[15]};
    endfunction

    task automatic model_step(input logic [31:0] c, input logic r);
        logic [15:0] rd, n_acc;
        logic [7:0]  n_pc, n_mar, n_ir;
        logic [15:0] n_mbr, n_br;
        logic [3:0]  n_flags;
        int s, ss, a;
        longint p, w;
        rd = m_mem[m_mar];
        if (c[11]) m_mem[m_mar] = m_mbr;
        if (r) begin
            m_pc = 8'h0; m_mar = 8'h0; m_ir = 8'h0; m_mbr = 16'h0; m_br = 16'h0;
            m_acc = 16'h0; m_flags = 4'h0; m_busy = 1'b0; m_left = 0;
            return;
        end
        n_mbr = c[3] ? rd : (c[12] ? m_acc : m_mbr);
        n_ir  = c[4] ? m_mbr[15:8] : m_ir;
        n_br  = c[7] ? m_mbr : m_br;
        n_mar = c[10] ? m_pc : (c[5] ? m_mbr[7:0] : m_mar);
        n_pc  = c[14] ? m_mbr[7:0] : (c[6] ? m_pc + 8'd1 : m_pc);
        n_acc = m_acc;
        n_flags = m_flags;
        a = int'(m_br[4:0]);
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                n_acc = m_quot; n_flags = flags_for(m_quot, 1'b0, 1'b0);
            end
        end else if (c[21]) begin
            n_acc = ~m_br; n_flags = flags_for(n_acc, 1'b0, 1'b0);
        end else if (c[8]) begin
            n_acc = 16'h0; n_flags = flags_for(n_acc, 1'b0, 1'b0);
        end else if (c[9]) begin
            s  = int'(m_acc) + int'(m_br);
            ss = int'($signed(m_acc)) + int'($signed(m_br));
            n_acc = 16'(s); n_flags = flags_for(n_acc, s > 65535, (ss > 32767) || (ss < -32768));
        end else if (c[13]) begin
            s  = int'(m_acc) - int'(m_br);
            ss = int'($signed(m_acc)) - int'($signed(m_br));
            n_acc = 16'(s); n_flags = flags_for(n_acc, m_acc < m_br, (ss > 32767) || (ss < -32768));
        end else if (c[15]) begin
            p = longint'(m_acc) * longint'(m_br);
            n_acc = 16'(p); n_flags = flags_for(n_acc, (p >> 16) != 0, (p >> 16) != 0);
        end else if (c[16]) begin
            if (m_br == 16'h0) begin
                n_acc = 16'hFFFF; n_flags = flags_for(n_acc, 1'b1, 1'b0);
            end else begin
                m_busy = 1'b1; m_left = 16; m_quot = m_acc / m_br;
            end
        end else if (c[17]) begin
            w = longint'(m_acc) << a;
            n_acc = 16'(w); n_flags = flags_for(n_acc, w[16], 1'b0);
        end else if (c[18]) begin
            n_acc = 16'(int'(m_acc) >> a);
            n_flags = flags_for(n_acc, (a == 0) ? 1'b0 : 1'((int'(m_acc) >> (a - 1)) & 1), 1'b0);
        end else if (c[19]) begin
            n_acc = m_acc & m_br; n_flags = flags_for(n_acc, 1'b0, 1'b0);
        end else if (c[20]) begin
            n_acc = m_acc | m_br; n_flags = flags_for(n_acc, 1'b0, 1'b0);
        end
        m_pc = n_pc; m_mar = n_mar; m_ir = n_ir; m_mbr = n_mbr; m_br = n_br;
        m_acc = n_acc; m_flags = n_flags;
    endtask

    // One clock: drive ctrl, advance model and environment memory, compare every output.
    task automatic step(input logic [31:0] c, input logic r = 1'b0);
        logic       wr;
        logic [7:0] wa;
        logic [15:0] wd;
        ctrl = c;
        rst  = r;
        #1;
        check_val("mem_we_pre", {31'h0, mem_we}, {31'h0, c[11]});
        wr = mem_we; wa = mem_addr; wd = mem_wdata;
        model_step(c, r);
        @(posedge clk);
        #1;
        if (wr) mem[wa] = wd;
        check_val("pc", {24'h0, pc_out}, {24'h0, m_pc});
        check_val("mar", {24'h0, mem_addr}, {24'h0, m_mar});
        check_val("mbr", {16'h0, mem_wdata}, {16'h0, m_mbr});
        check_val("ir", {24'h0, ir_out}, {24'h0, m_ir});
        check_val("acc", {16'h0, acc_out}, {16'h0, m_acc});
        check_val("flags", {28'h0, alu_flags}, {28'h0, m_flags});
        check_val("busy", {31'h0, div_busy}, {31'h0, m_busy});
    endtask

    task automatic poke(input logic [7:0] addr, input logic [15:0] v);
        mem[addr] = v;
        m_mem[addr] = v;
    endtask

    task automatic load_br(input logic [15:0] v);
        poke(m_mar, v);
        step(cb(3));
        step(cb(7));
    endtask

    task automatic load_acc(input logic [15:0] v);
        load_br(~v);
        step(cb(21));
    endtask

    initial begin
        logic [15:0] v;
        logic [31:0] c;
        int busy_cnt;
        for (int i = 0; i < 256; i++) begin
            v = (i % 4 == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            mem[i] = v;
            m_mem[i] = v;
        end
        ctrl = 32'h0;
        rst  = 1'b1;
        step(32'h0, 1'b1);
        step(32'h0, 1'b1);
        check_val("rst_pc", {24'h0, pc_out}, 32'h0);
        check_val("rst_acc", {16'h0, acc_out}, 32'h0);
        check_val("rst_flags", {28'h0, alu_flags}, 32'h0);

        // Fetch
        poke(8'h00, 16'h0205);
        step(cb(10)); step(cb(3)); step(cb(4)); step(cb(5) | cb(6));
        check_val("fetch_mar", {24'h0, mem_addr}, 32'h05);
        check_val("fetch_ir", {24'h0, ir_out}, 32'h02);
        check_val("fetch_pc", {24'h0, pc_out}, 32'h01);

        // Arithmetic and flags
        load_acc(16'h7FFF); load_br(16'h0001); step(cb(9));
        check_val("add_acc", {16'h0, acc_out}, 32'h8000);
        check_val("add_flags", {28'h0, alu_flags}, 32'h3);
        load_br(16'h8000); step(cb(13));
        check_val("sub_acc", {16'h0, acc_out}, 32'h0);
        check_val("sub_flags", {28'h0, alu_flags}, 32'h8);
        load_acc(16'h0000); load_br(16'h0001); step(cb(13));
        check_val("borrow_acc", {16'h0, acc_out}, 32'hFFFF);
        check_val("borrow_flags", {28'h0, alu_flags}, 32'h5);

        // Priority
        load_br(16'h00F0); step(cb(20) | cb(21));
        check_val("not_prio", {16'h0, acc_out}, 32'hFF0F);
        poke(m_mar, 16'h0033); step(cb(3)); step(cb(6) | cb(14));
        check_val("pc_prio", {24'h0, pc_out}, 32'h33);
        poke(m_mar, 16'hBEEF); step(cb(3) | cb(12));
        check_val("mbr_prio", {16'h0, mem_wdata}, 32'hBEEF);

        // Divide with an ignored add mid-flight
        load_acc(16'd100); load_br(16'd7);
        busy_cnt = 0;
        step(cb(16));
        for (int i = 0; i < 40 && div_busy; i++) begin
            busy_cnt++;
            step((i == 5) ? cb(9) : 32'h0);
        end
        check_val("div_busy_cycles", busy_cnt, 32'd16);
        check_val("div_quot", {16'h0, acc_out}, 32'd14);
        load_br(16'h0000); step(cb(16));
        check_val("div0_busy", {31'h0, div_busy}, 32'h0);
        check_val("div0_acc", {16'h0, acc_out}, 32'hFFFF);
        check_val("div0_flags", {28'h0, alu_flags}, 32'h5);

        // Shifts and multiply
        load_acc(16'h8001); load_br(16'h0001); step(cb(17));
        check_val("shl_acc", {16'h0, acc_out}, 32'h0002);
        check_val("shl_flags", {28'h0, alu_flags}, 32'h4);
        load_br(16'd20); step(cb(18));
        check_val("shr_acc", {16'h0, acc_out}, 32'h0);
        load_acc(16'h0100); load_br(16'h0100); step(cb(15));
        check_val("mul_acc", {16'h0, acc_out}, 32'h0);
        check_val("mul_flags", {28'h0, alu_flags}, 32'hE);

        // Reset mid-divide after a store
        load_acc(16'd1000); load_br(16'd3); step(cb(16)); step(32'h0); step(32'h0);
        step(cb(11));
        step(cb(11), 1'b1);
        check_val("rstdiv_acc", {16'h0, acc_out}, 32'h0);
        check_val("rstdiv_busy", {31'h0, div_busy}, 32'h0);
        check_val("rstdiv_pc", {24'h0, pc_out}, 32'h0);
        check_val("rstdiv_mbr", {16'h0, mem_wdata}, 32'h0);

        // Random control words
        for (int n = 0; n < 2000; n++) begin
            c = 32'($urandom) & 32'hFFC0_5CFF;
            c = c & ~32'h0000_0100;
            case ($urandom_range(0, 11))
                0: c |= cb(8);   1: c |= cb(9);   2: c |= cb(13);  3: c |= cb(15);
                4: c |= cb(16);  5: c |= cb(17);  6: c |= cb(18);  7: c |= cb(19);
                8: c |= cb(20);  9: c |= cb(21);  default: c = c;
            endcase
            if ($urandom_range(0, 3) == 0) c |= 32'($urandom) & 32'h003F_A300;
            if ($urandom_range(0, 7) == 0) poke(8'($urandom), 16'($urandom_range(0, 40)));
            step(c, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
